// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of FE speculative predictions, checked against execute.
// Optional saturating statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolve_unit #(
  parameter int PC_W         = 16,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     spec_v_i,
  input  logic                     spec_taken_i,
  input  logic [PC_W-1:0]          spec_alt_pc_i,
  output logic                     spec_ready_o,
  input  logic                     resolve_v_i,
  input  logic                     resolve_taken_i,
  input  logic                     resolve_is_bx_i,
  input  logic [PC_W-1:0]          resolve_target_i,
  output logic                     redirect_v_o,
  output logic [PC_W-1:0]          redirect_pc_o,
  output logic                     flush_o,
  output logic [$clog2(DEPTH):0]   outstanding_o,
  output logic [CNT_W-1:0]         mispredict_cnt_o,
  output logic [CNT_W-1:0]         resolved_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);
  localparam logic [FC_W-1:0]  FC_LOAD  = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] alt_pc;
  } rec_t;

  state_e            state_q, state_d;
  rec_t              mem_q [DEPTH];
  rec_t              mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              redirect_v_q, redirect_v_d;
  logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;

  rec_t head;
  logic push, resolve_acc, mispredict;

  assign head         = mem_q[rd_ptr_q];
  // Readiness looks only at registered count: a same-cycle pop never frees a slot.
  assign spec_ready_o = (state_q == ST_RUN) && (count_q < OCC_FULL);
  assign push         = spec_v_i && spec_ready_o;
  assign resolve_acc  = resolve_v_i && (state_q == ST_RUN) && (count_q != '0);
  // A taken exchange branch always redirects: the FE never knows its target.
  assign mispredict   = resolve_acc &&
                        ((resolve_taken_i != head.taken) || (resolve_is_bx_i && resolve_taken_i));

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    flush_cnt_d   = flush_cnt_q;
    redirect_v_d  = 1'b0;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_RUN: begin
        if (mispredict) begin
          // Everything still queued (and any same-cycle push) is younger: drop it.
          state_d       = ST_FLUSH;
          flush_cnt_d   = FC_LOAD;
          rd_ptr_d      = wr_ptr_q;
          count_d       = '0;
          redirect_v_d  = 1'b1;
          redirect_pc_d = resolve_is_bx_i ? resolve_target_i : head.alt_pc;
        end else begin
          if (push) begin
            mem_d[wr_ptr_q] = '{taken: spec_taken_i, alt_pc: spec_alt_pc_i};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
          end
          if (resolve_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
          end
          if (push && !resolve_acc) begin
            count_d = count_q + OCC_ONE;
          end else if (!push && resolve_acc) begin
            count_d = count_q - OCC_ONE;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_ONE;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      flush_cnt_q   <= '0;
      redirect_v_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_v_q  <= redirect_v_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign redirect_v_o  = redirect_v_q;
  assign redirect_pc_o = redirect_pc_q;
  assign flush_o       = (state_q == ST_FLUSH);
  assign outstanding_o = count_q;

`ifdef BRANCH_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  always_comb begin
    res_cnt_d = res_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (resolve_acc && (res_cnt_q != '1)) begin
      res_cnt_d = res_cnt_q + CNT_ONE;
    end
    if (mispredict && (mis_cnt_q != '1)) begin
      mis_cnt_d = mis_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      res_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      res_cnt_q <= res_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign resolved_cnt_o   = res_cnt_q;
  assign mispredict_cnt_o = mis_cnt_q;
`else
  assign resolved_cnt_o   = '0;
  assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios then random traffic against a queue model.
module tb_branch_resolve_unit;

  localparam int PC_W         = 16;
  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 16;

  logic                   clk_i = 1'b0;
  logic                   reset_n_i;
  logic                   spec_v_i, spec_taken_i;
  logic [PC_W-1:0]        spec_alt_pc_i;
  logic                   spec_ready_o;
  logic                   resolve_v_i, resolve_taken_i, resolve_is_bx_i;
  logic [PC_W-1:0]        resolve_target_i;
  logic                   redirect_v_o;
  logic [PC_W-1:0]        redirect_pc_o;
  logic                   flush_o;
  logic [$clog2(DEPTH):0] outstanding_o;
  logic [CNT_W-1:0]       mispredict_cnt_o, resolved_cnt_o;

  branch_resolve_unit #(
    .PC_W(PC_W), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .spec_v_i(spec_v_i), .spec_taken_i(spec_taken_i), .spec_alt_pc_i(spec_alt_pc_i),
    .spec_ready_o(spec_ready_o),
    .resolve_v_i(resolve_v_i), .resolve_taken_i(resolve_taken_i),
    .resolve_is_bx_i(resolve_is_bx_i), .resolve_target_i(resolve_target_i),
    .redirect_v_o(redirect_v_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .outstanding_o(outstanding_o),
    .mispredict_cnt_o(mispredict_cnt_o), .resolved_cnt_o(resolved_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: program-order list of predictions plus remaining flush cycles.
  typedef struct {
    bit              taken;
    logic [PC_W-1:0] alt;
  } mrec_t;

  mrec_t            mq[$];
  int               flush_left;
  logic             exp_rv;
  logic [PC_W-1:0]  exp_rpc;
  logic [CNT_W-1:0] exp_res, exp_mis;
  int               n_vec  = 0;
  int               n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    flush_left = 0;
    exp_rv     = 1'b0;
    exp_rpc    = '0;
    exp_res    = '0;
    exp_mis    = '0;
  endtask

  task automatic model_edge();
    bit    ready, push, mis;
    mrec_t head;
    ready  = (flush_left == 0) && (mq.size() < DEPTH);
    push   = spec_v_i && ready;
    exp_rv = 1'b0;
    if (flush_left > 0) begin
      flush_left--;
    end else begin
      if (resolve_v_i && mq.size() > 0) begin
        head = mq[0];
        mis  = (resolve_taken_i != head.taken) || (resolve_is_bx_i && resolve_taken_i);
        if (exp_res != '1) exp_res++;
        if (mis) begin
          if (exp_mis != '1) exp_mis++;
          mq.delete();
          flush_left = FLUSH_CYCLES;
          exp_rv     = 1'b1;
          exp_rpc    = resolve_is_bx_i ? resolve_target_i : head.alt;
          push       = 1'b0;
        end else begin
          void'(mq.pop_front());
        end
      end
      if (push) mq.push_back('{taken: spec_taken_i, alt: spec_alt_pc_i});
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".outstanding"}, 32'(outstanding_o), 32'(mq.size()));
    check({tag, ".ready"}, 32'(spec_ready_o), 32'((flush_left == 0) && (mq.size() < DEPTH)));
    check({tag, ".flush"}, 32'(flush_o), 32'(flush_left > 0));
    check({tag, ".redir_v"}, 32'(redirect_v_o), 32'(exp_rv));
    check({tag, ".redir_pc"}, 32'(redirect_pc_o), 32'(exp_rpc));
`ifdef BRANCH_STATS_EN
    check({tag, ".res_cnt"}, 32'(resolved_cnt_o), 32'(exp_res));
    check({tag, ".mis_cnt"}, 32'(mispredict_cnt_o), 32'(exp_mis));
`endif
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare #1 later.
  task automatic step(input string tag, input bit sv, input bit st, input logic [PC_W-1:0] sa,
                      input bit rv, input bit rt, input bit bx, input logic [PC_W-1:0] tg);
    spec_v_i         = sv;
    spec_taken_i     = st;
    spec_alt_pc_i    = sa;
    resolve_v_i      = rv;
    resolve_taken_i  = rt;
    resolve_is_bx_i  = bx;
    resolve_target_i = tg;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, '0, 0, 0, 0, '0);
  endtask

  task automatic do_reset(input string tag);
    reset_n_i = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    reset_n_i        = 1'b0;
    spec_v_i         = 1'b0;
    spec_taken_i     = 1'b0;
    spec_alt_pc_i    = '0;
    resolve_v_i      = 1'b0;
    resolve_taken_i  = 1'b0;
    resolve_is_bx_i  = 1'b0;
    resolve_target_i = '0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Fill to DEPTH; a further push must be dropped.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, i[0], 16'(16 * i + 4), 0, 0, 0, '0);
    check("fill.ready_low", 32'(spec_ready_o), 32'd0);
    check("fill.outstanding4", 32'(outstanding_o), 32'd4);
    step("fill_drop", 1, 1, 16'h7777, 0, 0, 0, '0);
    do_reset("reset2");

    // Correct prediction: pop only.
    step("s2_push", 1, 1, 16'h0104, 0, 0, 0, '0);
    step("s2_res", 0, 0, '0, 1, 1, 0, '0);
    check("s2.no_redirect", 32'(redirect_v_o), 32'd0);

    // Direction mispredict.
    step("s3_push", 1, 0, 16'h0200, 0, 0, 0, '0);
    step("s3_res", 0, 0, '0, 1, 1, 0, '0);
    check("s3.redir_pc", 32'(redirect_pc_o), 32'h0200);
    check("s3.flush_on", 32'(flush_o), 32'd1);
    idle("s3_f2");
    idle("s3_run");
    check("s3.ready_back", 32'(spec_ready_o), 32'd1);
`ifdef BRANCH_STATS_EN
    check("s3.res_cnt2", 32'(resolved_cnt_o), 32'd2);
    check("s3.mis_cnt1", 32'(mispredict_cnt_o), 32'd1);
`endif

    // Taken exchange branch redirects to its register target.
    step("s4_push", 1, 0, 16'h0010, 0, 0, 0, '0);
    step("s4_res", 0, 0, '0, 1, 1, 1, 16'h3FFE);
    check("s4.redir_pc", 32'(redirect_pc_o), 32'h3FFE);
    idle("s4_f2");
    idle("s4_run");

    // Mispredict with simultaneous push; resolve during flush ignored.
    for (int i = 0; i < 3; i++) step("s5_push", 1, 1, 16'(16'h0400 + i), 0, 0, 0, '0);
    step("s5_mis", 1, 1, 16'h0999, 1, 0, 0, '0);
    check("s5.outstanding0", 32'(outstanding_o), 32'd0);
    step("s5_flush_res", 1, 1, 16'h0aaa, 1, 0, 0, '0);
    check("s5.no_redirect", 32'(redirect_v_o), 32'd0);
    idle("s5_run");

    // Empty-queue resolve, then reset in the middle of a flush.
    step("s6_empty_res", 0, 0, '0, 1, 0, 0, '0);
    step("s6_push", 1, 1, 16'h0600, 0, 0, 0, '0);
    step("s6_mis", 0, 0, '0, 1, 0, 0, '0);
    do_reset("s6_reset_flush");
    check("s6.flush_off", 32'(flush_o), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 1)), 16'($urandom),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 4) != 0),
           bit'($urandom_range(0, 5) == 0), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
